// File: rtl/fifo_pkg.sv
// Shared types for the FIFO controller slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fifo_pkg;

    // Occupancy status; full/empty are decoded straight from this register.
    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } fifo_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: low bits address the RAM, MSB is the lap (wrap) bit.
// Latency: ptr updates one cycle after inc/clr is sampled.
// Backpressure: none; the caller only raises inc for accepted transfers.
//
// Ports:
//   wr_clk  - clock
//   reset_n - synchronous active-low reset (ptr -> 0)
//   inc     - advance by one (mod 2**PTR_W)
//   clr     - return to zero; wins over inc
//   ptr     - current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int PTR_W = 4
) (
    input  logic             wr_clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller sequencing an external async-read dual-port RAM.
// Latency: accepted push visible on dout / flags the cycle after its edge; pop advances dout next cycle.
// Backpressure: push refused while full unless a pop is accepted the same cycle; pop ignored while empty.
//
// Ports:
//   wr_clk, reset_n          - clock, synchronous active-low reset
//   push/din, pop            - client write request + data, read acknowledge
//   flush, err_clr           - clear pointers/count, clear sticky errors
//   dout                     - head word (ram_read_data), valid while !empty
//   full/empty/almost_*      - status flags; count = occupancy 0..DEPTH
//   overflow/underflow       - sticky error flags
//   ram_*                    - RAM write port, read address, always-on read enable, read data
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  wr_clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [PTR_W-1:0] CNT_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] CNT_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] CNT_AF    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] CNT_AE    = PTR_W'(AE_LEVEL);

    fifo_state_e      state;
    fifo_state_e      state_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_set;
    logic             unf_set;

    // ------------------------------------------------------------------
    // Acceptance. Pop is resolved first because a full FIFO can take a
    // push only when the head is leaving in the same cycle. No bypass:
    // on an empty FIFO only the push is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        ovf_set = push & full & ~pop;
        unf_set = pop & empty;
    end

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .wr_clk  (wr_clk),
        .reset_n (reset_n),
        .inc     (push_ok),
        .clr     (flush),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .wr_clk  (wr_clk),
        .reset_n (reset_n),
        .inc     (pop_ok),
        .clr     (flush),
        .ptr     (rd_ptr)
    );

    // ------------------------------------------------------------------
    // RAM side. The write enable is gated by reset_n as well as flush so
    // that nothing lands in the RAM while the controller is being reset,
    // even though state is still unknown before the first reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        ram_wr_en      = push_ok & ~flush & reset_n;
        ram_write_addr = wr_ptr[ADDR_WIDTH-1:0];
        ram_write_data = din;
        ram_read_addr  = rd_ptr[ADDR_WIDTH-1:0];
        ram_rd_en      = 1'b1;
        dout           = ram_read_data;
    end

    // ------------------------------------------------------------------
    // Status FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Status FSM: next state (and next count, which drives the same
    // boundary decisions)
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        count_nxt = count;

        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase

        unique case (state)
            S_EMPTY: begin
                if (push_ok) state_nxt = S_PARTIAL;
            end
            S_PARTIAL: begin
                if (push_ok && !pop_ok && count == CNT_DEPTH - CNT_ONE) begin
                    state_nxt = S_FULL;
                end else if (pop_ok && !push_ok && count == CNT_ONE) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop_ok && !push_ok) state_nxt = S_PARTIAL;
            end
            default: state_nxt = S_EMPTY;
        endcase

        if (flush) begin
            state_nxt = S_EMPTY;
            count_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Status FSM: outputs, decoded only from registered state/count
    // ------------------------------------------------------------------
    always_comb begin
        empty        = (state == S_EMPTY);
        full         = (state == S_FULL);
        almost_full  = (count >= CNT_AF);
        almost_empty = (count <= CNT_AE);
    end

    // ------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors: a new error in the err_clr cycle keeps the flag set.
    // flush leaves them alone.
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    // ------------------------------------------------------------------
    // The FSM-decoded flags and the counter must agree with the pointers.
    // ------------------------------------------------------------------
    logic ptr_empty;
    logic ptr_full;
    always_comb begin
        ptr_empty = (wr_ptr == rd_ptr);
        ptr_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    end

    a_flags_match_ptrs : assert property (@(posedge wr_clk) disable iff (!reset_n)
        (empty == ptr_empty) && (full == ptr_full));

    a_count_match_ptrs : assert property (@(posedge wr_clk) disable iff (!reset_n)
        (count == PTR_W'(wr_ptr - rd_ptr)) && (count <= CNT_DEPTH));

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl, with a behavioural async-read RAM.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit after the next posedge.
// Backpressure: exercised via full/empty boundary scenarios.
module tb_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          wr_clk = 1'b0;
    logic          reset_n;
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic          flush;
    logic          err_clr;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          ram_wr_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_write_data;
    logic          ram_rd_en;
    logic [DW-1:0] ram_read_data;

    int tests = 0;
    int fails = 0;

    always #5 wr_clk = ~wr_clk;

    fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .wr_clk         (wr_clk),
        .reset_n        (reset_n),
        .push           (push),
        .din            (din),
        .pop            (pop),
        .flush          (flush),
        .err_clr        (err_clr),
        .dout           (dout),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow),
        .ram_wr_en      (ram_wr_en),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_write_data (ram_write_data),
        .ram_rd_en      (ram_rd_en),
        .ram_read_data  (ram_read_data)
    );

    // Simple dual-port RAM, synchronous write, asynchronous read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge wr_clk) begin
        if (ram_wr_en) mem[ram_write_addr] <= ram_write_data;
    end
    assign ram_read_data = mem[ram_read_addr];

    // One clock cycle with the given inputs; returns 1 unit after the edge.
    task automatic cyc(input logic p, input logic [DW-1:0] d, input logic po,
                       input logic fl, input logic ec);
        push = p; din = d; pop = po; flush = fl; err_clr = ec;
        @(posedge wr_clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; push = 1'b1; din = 32'hBAD0_0001; pop = 1'b1; flush = 1'b0; err_clr = 1'b0;
        #2;
        tests++; if (ram_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en_pre: got %b expected 0", ram_wr_en); end
        @(posedge wr_clk); @(posedge wr_clk); #1;
        tests++; if (ram_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b expected 0", ram_wr_en); end
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_errs: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
        push = 1'b0; pop = 1'b0;
        @(posedge wr_clk); #1;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got e=%b ae=%b expected 1/1", empty, almost_empty); end
        tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin fails++; $display("FAIL reset_full: got f=%b af=%b expected 0/0", full, almost_full); end
        tests++; if (ram_rd_en !== 1'b1) begin fails++; $display("FAIL reset_rd_en: got %b expected 1", ram_rd_en); end
        tests++; if (ram_read_addr !== 3'd0 || ram_write_addr !== 3'd0) begin fails++; $display("FAIL reset_addr: got rd=%0d wr=%0d expected 0/0", ram_read_addr, ram_write_addr); end
        reset_n = 1'b1;
        @(posedge wr_clk); #1;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 32'(32'h11 * k), 1'b0, 1'b0, 1'b0);
            tests++; if (count !== 4'(k)) begin fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, count, k); end
            tests++; if (almost_full !== (k >= 6)) begin fails++; $display("FAIL fill_af[%0d]: got %b expected %b", k, almost_full, (k >= 6)); end
            tests++; if (almost_empty !== (k <= 2)) begin fails++; $display("FAIL fill_ae[%0d]: got %b expected %b", k, almost_empty, (k <= 2)); end
            tests++; if (full !== (k == 8) || empty !== 1'b0) begin fails++; $display("FAIL fill_flags[%0d]: got f=%b e=%b expected %b/0", k, full, empty, (k == 8)); end
            tests++; if (dout !== 32'h11) begin fails++; $display("FAIL fill_dout[%0d]: got %0h expected 11", k, dout); end
        end
    endtask

    task automatic test_overflow();
        push = 1'b1; din = 32'hDEAD_BEEF; #1;
        tests++; if (ram_wr_en !== 1'b0) begin fails++; $display("FAIL ovf_wr_en: got %b expected 0", ram_wr_en); end
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        tests++; if (count !== 4'd8 || full !== 1'b1) begin fails++; $display("FAIL ovf_count: got %0d f=%b expected 8/1", count, full); end
        tests++; if (dout !== 32'h11) begin fails++; $display("FAIL ovf_dout: got %0h expected 11", dout); end
        // a new overflow in the clearing cycle keeps the flag
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_clr_count: got %0d expected 8", count); end
    endtask

    task automatic test_push_pop_full();
        logic [DW-1:0] exp_w [8];
        exp_w = '{32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99};
        push = 1'b1; din = 32'h99; pop = 1'b1; #1;
        tests++; if (ram_wr_en !== 1'b1 || ram_write_addr !== 3'd0) begin fails++; $display("FAIL ppf_write: got en=%b addr=%0d expected 1/0", ram_wr_en, ram_write_addr); end
        cyc(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
        tests++; if (count !== 4'd8 || full !== 1'b1) begin fails++; $display("FAIL ppf_count: got %0d f=%b expected 8/1", count, full); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ppf_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (dout !== exp_w[i]) begin fails++; $display("FAIL ppf_dout[%0d]: got %0h expected %0h", i, dout, exp_w[i]); end
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tests++; if (count !== 4'(7 - i)) begin fails++; $display("FAIL ppf_count[%0d]: got %0d expected %0d", i, count, 7 - i); end
        end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL ppf_empty: got e=%b f=%b expected 1/0", empty, full); end
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL ppf_unf: got %b expected 0", underflow); end
    endtask

    task automatic test_underflow();
        // 9 words in, 9 words out: both pointers at address 1
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_set: got %b expected 1", underflow); end
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL unf_count: got %0d e=%b expected 0/1", count, empty); end
        tests++; if (ram_read_addr !== 3'd1 || ram_write_addr !== 3'd1) begin fails++; $display("FAIL unf_ptrs: got rd=%0d wr=%0d expected 1/1", ram_read_addr, ram_write_addr); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL unf_clr: got %b expected 0", underflow); end
        // push+pop on empty: only the push is taken, and the pop still flags underflow
        cyc(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0);
        tests++; if (count !== 4'd1 || empty !== 1'b0) begin fails++; $display("FAIL pp_empty_count: got %0d e=%b expected 1/0", count, empty); end
        tests++; if (dout !== 32'h5A5A_5A5A) begin fails++; $display("FAIL pp_empty_dout: got %0h expected 5a5a5a5a", dout); end
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL pp_empty_unf: got %b expected 1", underflow); end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tests++; if (empty !== 1'b1 || underflow !== 1'b0) begin fails++; $display("FAIL pp_empty_drain: got e=%b unf=%b expected 1/0", empty, underflow); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] q [$];
        logic [DW-1:0] w;
        logic          p, po, push_acc, pop_acc;
        int            sent = 0;
        for (int c = 0; c < 100 && !(sent == 20 && q.size() == 0); c++) begin
            p        = (sent < 20) && (c % 4 != 3);
            po       = (c >= 5) && ((c % 2 == 0) || (sent >= 20));
            pop_acc  = po && (q.size() > 0);
            push_acc = p && ((q.size() < 8) || pop_acc);
            w        = 32'hC000_0000 + 32'(sent);
            if (pop_acc) begin
                tests++; if (dout !== q[0]) begin fails++; $display("FAIL wrap_dout[c%0d]: got %0h expected %0h", c, dout, q[0]); end
            end
            cyc(p, w, po, 1'b0, 1'b0);
            if (pop_acc) void'(q.pop_front());
            if (push_acc) begin
                q.push_back(w);
                sent++;
            end
            tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL wrap_count[c%0d]: got %0d expected %0d", c, count, q.size()); end
            tests++; if (full !== (q.size() == 8) || empty !== (q.size() == 0)) begin fails++; $display("FAIL wrap_flags[c%0d]: got f=%b e=%b expected %b/%b", c, full, empty, (q.size() == 8), (q.size() == 0)); end
        end
        tests++; if (!(sent == 20 && q.size() == 0)) begin fails++; $display("FAIL wrap_drain: got sent=%0d left=%0d expected 20/0", sent, q.size()); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
        tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        push = 1'b1; din = 32'hEE; flush = 1'b1; #1;
        tests++; if (ram_wr_en !== 1'b0) begin fails++; $display("FAIL flush_wr_en: got %b expected 0", ram_wr_en); end
        cyc(1'b1, 32'hEE, 1'b0, 1'b1, 1'b0);
        tests++; if (count !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin fails++; $display("FAIL flush_state: got %0d e=%b ae=%b expected 0/1/1", count, empty, almost_empty); end
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL flush_keeps_err: got %b expected 1", underflow); end
        tests++; if (ram_read_addr !== 3'd0 || ram_write_addr !== 3'd0) begin fails++; $display("FAIL flush_ptrs: got rd=%0d wr=%0d expected 0/0", ram_read_addr, ram_write_addr); end
        cyc(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
        tests++; if (dout !== 32'hA5 || count !== 4'd1) begin fails++; $display("FAIL flush_readback: got %0h cnt=%0d expected a5/1", dout, count); end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tests++; if (empty !== 1'b1 || underflow !== 1'b0) begin fails++; $display("FAIL flush_drain: got e=%b unf=%b expected 1/0", empty, underflow); end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 3; k++) cyc(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0, 1'b0);
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL rst_mid_pre: got %0d expected 3", count); end
        reset_n = 1'b0; push = 1'b1; din = 32'hBAD; pop = 1'b1; #1;
        tests++; if (ram_wr_en !== 1'b0) begin fails++; $display("FAIL rst_mid_wr_en: got %b expected 0", ram_wr_en); end
        @(posedge wr_clk); #1;
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL rst_mid_state: got %0d e=%b expected 0/1", count, empty); end
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL rst_mid_errs: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
        reset_n = 1'b1; push = 1'b0; pop = 1'b0;
        cyc(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
        tests++; if (dout !== 32'hA5 || count !== 4'd1 || empty !== 1'b0) begin fails++; $display("FAIL rst_mid_readback: got %0h cnt=%0d e=%b expected a5/1/0", dout, count, empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_push_pop_full();
        test_underflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_ctrl
